// File: rtl/burst_mem_responder_pkg.sv
// Shared types and constants for the 4-beat x 64-bit cache-line burst responder.
package burst_mem_types;

  localparam int unsigned BEAT_W     = 64;
  localparam int unsigned BEATS      = 4;
  localparam int unsigned LINE_BYTES = 32;
  localparam int unsigned OFFSET_W   = 5;

  typedef logic [BEAT_W-1:0] beat_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    BURST,
    DONE
  } bm_state_t;

endpackage

// File: rtl/burst_mem_responder_array.sv
// Line storage: DEPTH_LINES lines of four 64-bit beats, combinational read, clocked write.
module burst_mem_array
  import burst_mem_types::*;
#(
  parameter int unsigned DEPTH_LINES = 256,
  localparam int unsigned IDX_W      = $clog2(DEPTH_LINES)
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [1:0]       rd_beat,
  output beat_t            rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [1:0]       wr_beat,
  input  beat_t            wr_data
);

  beat_t mem [DEPTH_LINES*BEATS];

  assign rd_data = mem[{rd_idx, rd_beat}];

  // Deliberately no reset: contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{wr_idx, wr_beat}] <= wr_data;
    end
  end

endmodule

// File: rtl/burst_mem_responder.sv
// Backing-memory responder for the CPU line-burst port: latency, 4-beat burst, violation flag.
module burst_mem_responder
  import burst_mem_types::*;
#(
  parameter int unsigned LATENCY     = 8,
  parameter int unsigned DEPTH_LINES = 256,
  localparam int unsigned IDX_W      = $clog2(DEPTH_LINES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_addr,
  input  logic [63:0] mem_wdata,
  output logic [63:0] mem_rdata,
  output logic        mem_resp,
  output logic        busy,
  output logic        protocol_err
);

  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;

  bm_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       beat_q, beat_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             is_wr_q, is_wr_d;
  logic             resp_q, resp_d;
  beat_t            rdata_q, rdata_d;
  logic             busy_q, busy_d;
  logic             perr_q, perr_d;

  logic  req_held, req_other, abort;
  logic  wr_en;
  beat_t arr_rdata;

  logic unused_addr;
  assign unused_addr = ^{mem_addr[31:OFFSET_W+IDX_W], mem_addr[OFFSET_W-1:0]};

  // Losing the latched request, or the other request line rising, both end the transaction.
  assign req_held  = is_wr_q ? mem_write : mem_read;
  assign req_other = is_wr_q ? mem_read  : mem_write;
  assign abort     = !req_held || req_other;

  burst_mem_array #(
    .DEPTH_LINES (DEPTH_LINES)
  ) u_array (
    .clk     (clk),
    .rd_idx  (idx_q),
    .rd_beat (beat_d),
    .rd_data (arr_rdata),
    .wr_en   (wr_en),
    .wr_idx  (idx_q),
    .wr_beat (beat_q),
    .wr_data (mem_wdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      beat_q  <= '0;
      idx_q   <= '0;
      is_wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      idx_q   <= idx_d;
      is_wr_q <= is_wr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    idx_d   = idx_q;
    is_wr_d = is_wr_q;
    unique case (state_q)
      IDLE: begin
        if (mem_read ^ mem_write) begin
          state_d = WAIT;
          cnt_d   = CNT_W'(LATENCY);
          beat_d  = '0;
          idx_d   = mem_addr[OFFSET_W +: IDX_W];
          is_wr_d = mem_write;
        end
      end
      WAIT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = BURST;
          beat_d  = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      BURST: begin
        if (abort) begin
          state_d = IDLE;
        end else if (beat_q == 2'd3) begin
          state_d = DONE;
        end else begin
          beat_d = beat_q + 2'd1;
        end
      end
      DONE: begin
        if (!mem_read && !mem_write) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // Output registers are loaded from the state being entered so they line up with it.
  always_comb begin
    resp_d  = (state_d == BURST);
    rdata_d = (state_d == BURST && !is_wr_d) ? arr_rdata : '0;
    busy_d  = (state_d != IDLE);
    wr_en   = (state_q == BURST) && is_wr_q && !abort;
    perr_d  = perr_q
            | ((state_q == IDLE) && mem_read && mem_write)
            | (((state_q == WAIT) || (state_q == BURST)) && abort);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_q  <= 1'b0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      resp_q  <= resp_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      perr_q  <= perr_d;
    end
  end

  assign mem_resp     = resp_q;
  assign mem_rdata    = rdata_q;
  assign busy         = busy_q;
  assign protocol_err = perr_q;

endmodule

// File: tb/tb_burst_mem_responder.sv
// Scoreboard bench for burst_mem_responder: line-level reference model, randomized bursts.
module tb_burst_mem_responder;
  import burst_mem_types::*;

  localparam int unsigned LAT   = 2;
  localparam int unsigned DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [63:0] mem_wdata = '0;
  logic [63:0] mem_rdata;
  logic        mem_resp;
  logic        busy;
  logic        protocol_err;

  burst_mem_responder #(
    .LATENCY     (LAT),
    .DEPTH_LINES (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp),
    .busy         (busy),
    .protocol_err (protocol_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rd;
    logic [63:0] d;
  } exp_t;

  int          total = 0;
  int          bad = 0;
  logic [63:0] mdl [DEPTH][4];
  bit          vld [DEPTH];
  bit          exp_perr = 1'b0;
  exp_t        sbq[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Memory is a flat array of lines; the line number is the byte address over the line size.
  function automatic int lidx(input logic [31:0] a);
    return int'((a / LINE_BYTES) % DEPTH);
  endfunction

  // Monitor: every beat strobe consumes one scoreboard entry.
  always @(negedge clk) begin
    if (rst) begin
      if (mem_resp) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_resp: got resp=1 want no beat at %0t", $time);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          if (e.rd) chk("rdata", mem_rdata, e.d);
        end
      end else begin
        chk("rdata_idle_zero", mem_rdata, 64'd0);
      end
    end
  end

  // drop_beat / rst_beat: beat index during which the request drops / reset hits (-1: none).
  task automatic burst(input bit wr, input logic [31:0] addr, input logic [3:0][63:0] d,
                       input int drop_beat, input int rst_beat);
    int   li;
    int   cyc;
    int   nshow;
    exp_t e;
    li    = lidx(addr);
    nshow = (drop_beat >= 0) ? drop_beat + 1 : 4;
    for (int n = 0; n < nshow; n++) begin
      e.rd = !wr;
      e.d  = mdl[li][n];
      sbq.push_back(e);
    end
    @(posedge clk); #1;
    mem_addr  = addr;
    mem_read  = !wr;
    mem_write = wr;
    mem_wdata = d[0];
    @(posedge clk); #1;
    mem_addr = $urandom;
    cyc = 0;
    while (!mem_resp && cyc < int'(LAT) + 20) begin
      chk("busy_wait", {63'd0, busy}, 64'd1);
      @(posedge clk); #1;
      cyc++;
    end
    chk("first_resp_latency", 64'(cyc), 64'(LAT + 1));
    if (!mem_resp) begin
      sbq.delete();
      mem_read  = 1'b0;
      mem_write = 1'b0;
      repeat (4) @(posedge clk);
      return;
    end
    for (int n = 0; n < 4; n++) begin
      chk("resp_high", {63'd0, mem_resp}, 64'd1);
      if (wr) mem_wdata = d[n];
      if (n == rst_beat) begin
        #2 rst = 1'b0;
        #1;
        chk("rst_resp", {63'd0, mem_resp}, 64'd0);
        chk("rst_rdata", mem_rdata, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_perr", {63'd0, protocol_err}, 64'd0);
        sbq.delete();
        exp_perr  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        return;
      end
      if (n == drop_beat) begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(posedge clk); #1;
        exp_perr = 1'b1;
        chk("abort_resp", {63'd0, mem_resp}, 64'd0);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_perr", {63'd0, protocol_err}, 64'd1);
        return;
      end
      if (wr) mdl[li][n] = d[n];
      @(posedge clk); #1;
    end
    if (wr) vld[li] = 1'b1;
    chk("done_resp", {63'd0, mem_resp}, 64'd0);
    chk("done_busy", {63'd0, busy}, 64'd1);
    chk("perr", {63'd0, protocol_err}, {63'd0, exp_perr});
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(posedge clk); #1;
    chk("idle_busy", {63'd0, busy}, 64'd0);
  endtask

  task automatic fill(input logic [63:0] base, output logic [3:0][63:0] d);
    for (int n = 0; n < 4; n++) d[n] = base + 64'(n) * 64'h1111_1111_1111_1111;
  endtask

  initial begin
    logic [3:0][63:0] d;
    logic [31:0]      a;
    int               li;
    #3;
    chk("reset_resp", {63'd0, mem_resp}, 64'd0);
    chk("reset_rdata", mem_rdata, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_perr", {63'd0, protocol_err}, 64'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    d[0] = 64'hA0A0_A0A0_A0A0_A0A0; d[1] = 64'hB1B1_B1B1_B1B1_B1B1;
    d[2] = 64'hC2C2_C2C2_C2C2_C2C2; d[3] = 64'hD3D3_D3D3_D3D3_D3D3;
    burst(1'b1, 32'h40, d, -1, -1);
    burst(1'b0, 32'h40, d, -1, -1);

    fill(64'h1111_1111_1111_1111, d);
    burst(1'b1, 32'h100, d, -1, -1);
    burst(1'b0, 32'h100, d, -1, -1);

    fill(64'h0123_4567_89AB_CDEF, d);
    burst(1'b1, 32'h200, d, -1, -1);
    fill(64'h5555_0000_5555_0000, d);
    burst(1'b1, 32'h200, d, 2, -1);
    burst(1'b0, 32'h200, d, -1, -1);

    // Both request lines high while idle must never start a burst.
    @(posedge clk); #1;
    mem_read  = 1'b1;
    mem_write = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      chk("both_resp", {63'd0, mem_resp}, 64'd0);
      chk("both_busy", {63'd0, busy}, 64'd0);
    end
    chk("both_perr", {63'd0, protocol_err}, 64'd1);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    burst(1'b0, 32'h40, d, -1, -1);

    burst(1'b0, 32'h100, d, -1, 2);
    burst(1'b0, 32'h100, d, -1, -1);

    fill(64'hFEED_0000_0000_0001, d);
    burst(1'b1, 32'h2000, d, -1, -1);
    burst(1'b0, 32'h0000, d, -1, -1);

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 1) == 0) begin
        a  = $urandom;
        li = lidx(a);
        for (int n = 0; n < 4; n++) d[n] = {$urandom, $urandom};
        burst(1'b1, a, d, (vld[li] && $urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1,
              -1);
      end else begin
        a  = {$urandom_range(0, 255), 8'h00} | 32'h40;
        li = lidx(a);
        if (vld[li]) begin
          burst(1'b0, a, d, ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1, -1);
        end
      end
    end

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
